// File: rtl/traffic_density_encoder.sv
// traffic_density_encoder
// Per-approach vehicle-density encoder. The raw loop detector is synchronised
// and debounced, and rising edges of the filtered state are counted as vehicle
// arrivals over a fixed window. At each window boundary the count is published
// together with a 2-bit traffic level. A loop that stays occupied too long
// raises stuck_fault and forces the level to the fail-safe maximum.
// Optional feature: define TRAFFIC_DENSITY_HYST_EN to enable level hysteresis
// (a decrease needs two consecutive lower windows).
module traffic_density_encoder #(
    parameter int WINDOW    = 1000,
    parameter int DEBOUNCE  = 4,
    parameter int TH_LOW    = 1,
    parameter int TH_MED    = 5,
    parameter int TH_HIGH   = 10,
    parameter int CNT_W     = 8,
    parameter int STUCK_MAX = 5000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             loop_in,
    output logic [1:0]       level,
    output logic             level_valid,
    output logic [CNT_W-1:0] count_last,
    output logic             stuck_fault
);

    localparam int WIN_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int ST_W  = $clog2(STUCK_MAX + 1);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [ST_W-1:0]  ST_LIMIT = ST_W'(STUCK_MAX);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    // Map a window count onto the 2-bit traffic level.
    function automatic logic [1:0] classify(input logic [CNT_W-1:0] c);
        logic [31:0] cw;
        cw = 32'(c);
        if (cw < 32'(TH_LOW))
            return 2'b00;
        else if (cw < 32'(TH_MED))
            return 2'b01;
        else if (cw < 32'(TH_HIGH))
            return 2'b10;
        else
            return 2'b11;
    endfunction

    logic             sync1_q, sync2_q;
    logic             filt_q, filt_d;
    logic [DB_W-1:0]  db_q, db_d;
    logic [ST_W-1:0]  st_q, st_d;
    logic             fault_q, fault_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic [CNT_W-1:0] cnt_last_q, cnt_last_d;
    logic [1:0]       level_q, level_d;
    logic [1:0]       level_out_q, level_out_d;
    logic             vld_q, vld_d;

    logic             evt;
    logic             terminal;
    logic [CNT_W-1:0] vcnt_inc;
    logic [1:0]       cls;

    // Debounce, event detection, window counting and stuck supervision.
    always_comb begin
        filt_d = filt_q;
        db_d   = '0;
        if (sync2_q != filt_q) begin
            if (db_q == DB_LAST) begin
                filt_d = sync2_q;
            end else begin
                db_d = db_q + DB_W'(1);
            end
        end

        // An arrival is the filtered state going high; ignored while stuck.
        evt      = filt_d & ~filt_q & ~fault_q;
        vcnt_inc = (evt && (vcnt_q != CNT_SAT)) ? vcnt_q + CNT_W'(1) : vcnt_q;

        terminal   = (win_q == WIN_LAST);
        win_d      = terminal ? '0 : win_q + WIN_W'(1);
        vcnt_d     = terminal ? '0 : vcnt_inc;
        cnt_last_d = terminal ? vcnt_inc : cnt_last_q;
        vld_d      = terminal;
        cls        = classify(vcnt_inc);

        if (filt_q)
            st_d = (st_q == ST_LIMIT) ? st_q : st_q + ST_W'(1);
        else
            st_d = '0;
        fault_d = filt_q & (fault_q | (st_q == ST_LIMIT));
    end

`ifdef TRAFFIC_DENSITY_HYST_EN
    logic       pend_q, pend_d;
    logic [1:0] pend_cls_q, pend_cls_d;

    // Level update with hysteresis: rises apply at once, a fall needs two lower windows.
    always_comb begin
        level_d    = level_q;
        pend_d     = pend_q;
        pend_cls_d = pend_cls_q;
        if (terminal) begin
            if (cls >= level_q) begin
                level_d = cls;
                pend_d  = 1'b0;
            end else if (pend_q) begin
                level_d = (cls > pend_cls_q) ? cls : pend_cls_q;
                pend_d  = 1'b0;
            end else begin
                pend_d     = 1'b1;
                pend_cls_d = cls;
            end
        end
    end

    // Hysteresis state: pending flag and the first lower classification.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= 1'b0;
            pend_cls_q <= 2'b00;
        end else begin
            pend_q     <= pend_d;
            pend_cls_q <= pend_cls_d;
        end
    end
`else
    // Level update without hysteresis: each window's classification applies directly.
    always_comb begin
        level_d = terminal ? cls : level_q;
    end
`endif

    // The visible level is forced to maximum while the loop is stuck.
    always_comb begin
        level_out_d = fault_d ? 2'b11 : level_d;
    end

    // State registers; every stage returns to idle on asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            filt_q      <= 1'b0;
            db_q        <= '0;
            st_q        <= '0;
            fault_q     <= 1'b0;
            win_q       <= '0;
            vcnt_q      <= '0;
            cnt_last_q  <= '0;
            level_q     <= 2'b00;
            level_out_q <= 2'b00;
            vld_q       <= 1'b0;
        end else begin
            sync1_q     <= loop_in;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            db_q        <= db_d;
            st_q        <= st_d;
            fault_q     <= fault_d;
            win_q       <= win_d;
            vcnt_q      <= vcnt_d;
            cnt_last_q  <= cnt_last_d;
            level_q     <= level_d;
            level_out_q <= level_out_d;
            vld_q       <= vld_d;
        end
    end

    assign level       = level_out_q;
    assign level_valid = vld_q;
    assign count_last  = cnt_last_q;
    assign stuck_fault = fault_q;

endmodule

// File: doc/traffic_density_encoder.md
# traffic_density_encoder

Per-approach vehicle-density encoder that feeds the traffic controller's 2-bit `sensor_*` inputs. It synchronises and debounces a raw inductive-loop detector and counts vehicle arrivals over a fixed measurement window. At each window boundary it classifies the count into a 2-bit traffic level. One instance is used per approach (north/south/east/west), and the `level` output connects directly to the matching controller sensor input.

## Interface

Parameters:
- `WINDOW`, default 1000: clock cycles per measurement window (≥ 2).
- `DEBOUNCE`, default 4: consecutive stable cycles required before the filtered detector state changes (≥ 1).
- `TH_LOW`, default 1: minimum count for level 01.
- `TH_MED`, default 5: minimum count for level 10.
- `TH_HIGH`, default 10: minimum count for level 11. Requires TH_LOW ≤ TH_MED ≤ TH_HIGH.
- `CNT_W`, default 8: vehicle counter width; the counter saturates at 2^CNT_W−1.
- `STUCK_MAX`, default 5000: cycles of continuous occupancy that declare a stuck loop.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high.
- `loop_in`, in, 1: raw detector; high while a vehicle is over the loop; asynchronous to `clk`.
- `level`, out, 2: traffic level; 00 none, 01 low, 10 medium, 11 high.
- `level_valid`, out, 1: one-cycle pulse when `level`/`count_last` update.
- `count_last`, out, CNT_W: vehicle count of the last completed window.
- `stuck_fault`, out, 1: loop stuck-occupied indicator.

## Operation

- **Reset values:** `level`=00, `level_valid`=0, `count_last`=0, `stuck_fault`=0. All internal state is also reset: synchroniser, filtered state, debounce counter, window counter, vehicle count, stuck counter and hysteresis flag.
- **Synchroniser:** two flops on `loop_in` produce `sync`.
- **Debounce:** `filt` takes the value of `sync` only after `sync` has differed from `filt` for DEBOUNCE consecutive cycles. Any return to agreement clears the debounce counter.
- **Vehicle event:** a rising edge of `filt`. Each event increments the vehicle count, saturating at all-ones.
- **Window counter:** runs 0..WINDOW−1 and wraps continuously, independent of traffic.
- **Terminal cycle (counter = WINDOW−1):**
  - On the next edge, `count_last` receives the window count, including any event in the terminal cycle.
  - The vehicle count clears to 0.
  - `level` is updated per the classification rules.
  - `level_valid` pulses.
- **Classification of count c:** c < TH_LOW → 00; c < TH_MED → 01; c < TH_HIGH → 10; otherwise 11.
- **Stuck detection:**
  - The stuck counter increments while `filt`=1 and clears when `filt`=0.
  - When it reaches STUCK_MAX, `stuck_fault` is set.
  - While `stuck_fault`=1: `level` output is forced to 11 (fail-safe maximum green), new events are ignored, and window boundaries still pulse `level_valid` with the true `count_last`.
  - `stuck_fault` clears on the edge after `filt` falls.
  - After the fault clears, the forced 11 is released at once and `level` shows the last classified value.
- **Asynchronous reset mid-window:** discards the partial count; the window restarts at 0.

## Timing

- `loop_in` rise → event counted: 2 (sync) + DEBOUNCE cycles.
- Terminal cycle → `level`, `count_last` and `level_valid` all valid on the following edge, registered together.
- `level_valid` period is exactly WINDOW cycles. The first pulse occurs WINDOW cycles after reset release.
- `filt` high continuously for STUCK_MAX cycles → `stuck_fault`=1 on the following edge.
- All outputs are registered. No combinational path runs from `loop_in` to any output.

## Configuration

- **With `TRAFFIC_DENSITY_HYST_EN` defined:**
  - Increases in classified level apply at the window boundary immediately.
  - A decrease applies only when two consecutive windows both classify lower than the current `level`.
  - The applied value is the higher of those two classifications.
  - A one-bit pending flag tracks the first lower window and clears on any window that is not lower.
- **Without the macro:** `level` takes each window's classification directly, and no pending flag exists.

## Test plan

Parameters for all scenarios: WINDOW=100, DEBOUNCE=4, TH_LOW=1, TH_MED=3, TH_HIGH=6, STUCK_MAX=50.

1. No `loop_in` activity after reset → `level_valid` pulses every 100 cycles; `level`=00, `count_last`=0, `stuck_fault`=0.
2. Four clean pulses (10 cycles high, 10 low) in one window → `count_last`=4, `level`=10.
3. Five 3-cycle glitches on `loop_in` → `count_last`=0, `level`=00.
4. Hysteresis sequence: window with 7 pulses → `level`=11; next window 0 pulses; third window 0 pulses.
   - With macro: `level` stays 11 after the second window and drops to 00 after the third.
   - Without macro: `level`=00 after the second window.
5. `loop_in` held high for 80 cycles → `stuck_fault` rises 2+4+50 cycles (+1 edge) after the rise, with `level`=11. After release, `stuck_fault` clears 2+4+1 cycles later and `level` returns to the classified value.
6. Reset asserted at window cycle 60 after 2 counted pulses → all outputs return to reset values; the next `level_valid` arrives 100 cycles after reset release with `count_last`=0.
